// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: controller state encoding, base opcodes and
// PC source selects used by the control sequencer and the datapath.
package rv32i_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } ctrl_state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Table of every opcode the core implements; order is irrelevant.
    localparam int NUM_LEGAL_OPS = 9;
    localparam logic [6:0] LEGAL_OPS [NUM_LEGAL_OPS] = '{
        OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
        OP_JAL, OP_JALR, OP_LUI, OP_AUIPC
    };

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_JALR  = 2'b10;

endpackage

// File: rtl/rv32i_opc_legal.sv
// Combinational opcode check: legal=1 when the opcode is one of the
// implemented RV32I base opcodes.
module rv32i_opc_legal
    import rv32i_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       legal
);

    logic [NUM_LEGAL_OPS-1:0] hit;

    // One comparator per table entry, OR-reduced below.
    generate
        for (genvar gi = 0; gi < NUM_LEGAL_OPS; gi++) begin : g_match
            assign hit[gi] = (opcode == LEGAL_OPS[gi]);
        end
    endgenerate

    assign legal = |hit;

endmodule

// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle RV32I control sequencer: FETCH -> DECODE -> EXEC -> MEM -> WB,
// with memory handshakes, datapath strobes, opcode trap and a retired
// instruction counter.
module rv32i_mc_ctrl
    import rv32i_pkg::*;
#(
    parameter int INSTRET_W = 32,
    parameter bit TRAP_EN   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic                 reg_write,
    input  logic                 alu_src,
    input  logic                 jump,
    input  logic                 mem_to_reg,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic                 branch,
    input  logic                 jalr,
    input  logic                 br_taken,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic                 imem_req,
    output logic                 ir_we,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic                 rf_we,
    output logic                 wb_sel,
    output logic                 pc_we,
    output logic [1:0]           pc_sel,
    output logic                 halted,
    output logic [2:0]           state,
    output logic [INSTRET_W-1:0] instret
);

    localparam logic [2:0] S_FETCH  = ST_FETCH;
    localparam logic [2:0] S_DECODE = ST_DECODE;
    localparam logic [2:0] S_EXEC   = ST_EXEC;
    localparam logic [2:0] S_MEM    = ST_MEM;
    localparam logic [2:0] S_WB     = ST_WB;
    localparam logic [2:0] S_HALT   = ST_HALT;

    logic [2:0]           state_reg, state_next;
    logic                 taken_reg, taken_next;
    logic [INSTRET_W-1:0] instret_reg;
    logic                 opc_legal;
    logic                 retire;

    // alu_src steers the datapath only; the sequencer has no use for it.
    logic unused_inputs;
    assign unused_inputs = alu_src;

    rv32i_opc_legal u_opc_legal (
        .opcode (opcode),
        .legal  (opc_legal)
    );

    // Next-state selection; the spare encodings recover to FETCH.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:  if (imem_ready) state_next = S_DECODE;
            S_DECODE: begin
                if (opc_legal)    state_next = S_EXEC;
                else if (TRAP_EN) state_next = S_HALT;
                else              state_next = S_WB;
            end
            S_EXEC:   state_next = (mem_read | mem_write) ? S_MEM : S_WB;
            S_MEM:    if (dmem_ready) state_next = mem_write ? S_FETCH : S_WB;
            S_WB:     state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_FETCH;
        endcase
    end

    // Taken flag: cleared in DECODE so an untrapped unknown opcode (which
    // skips EXEC) never inherits the previous instruction's decision.
    always_comb begin
        taken_next = taken_reg;
        if (state_reg == S_DECODE)
            taken_next = 1'b0;
        else if (state_reg == S_EXEC)
            taken_next = jump | (branch & br_taken);
    end

    // State and taken-flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
            taken_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            taken_reg <= taken_next;
        end
    end

    // Output decode. Requests come from registered state only; ir_we and the
    // store pc_we mark the completion cycle of a transfer, so they are
    // qualified by the ready of that cycle. Everything is forced low while
    // rst_n is low so an in-flight request drops immediately.
    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = PC_PLUS4;
        halted   = 1'b0;
        if (rst_n) begin
            case (state_reg)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ready;
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = mem_write;
                    pc_we    = mem_write & dmem_ready;
                end
                S_WB: begin
                    rf_we  = reg_write & opc_legal;
                    wb_sel = mem_to_reg;
                    pc_we  = 1'b1;
                    if (!opc_legal)     pc_sel = PC_PLUS4;
                    else if (jalr)      pc_sel = PC_JALR;
                    else if (taken_reg) pc_sel = PC_IMM;
                    else                pc_sel = PC_PLUS4;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

    // Every PC update retires exactly one instruction.
    assign retire = pc_we;

    // Retired-instruction counter, wrapping at 2^INSTRET_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            instret_reg <= '0;
        else if (retire)
            instret_reg <= instret_reg + INSTRET_W'(1);
    end

    assign state   = state_reg;
    assign instret = instret_reg;

endmodule
